// File: rtl/instr_pkg.sv
// instr_pkg: MIPS-32 opcode/funct constants, field widths and format classification shared by encode and decode
package instr_pkg;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int JADDR_W  = 26;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [FUNCT_W-1:0]  FUNCT_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0]  FUNCT_SRL = 6'h02;
  localparam logic [FUNCT_W-1:0]  FUNCT_SRA = 6'h03;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;
  function automatic fmt_t fmt_of(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) ? FMT_R : (op == OP_J || op == OP_JAL) ? FMT_J : FMT_I;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with occupancy count; caller qualifies push/pop, head reads as zero when empty
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  // pointers wrap naturally at the power-of-two depth; level tracks push minus pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
  // storage is deliberately left unreset; emptiness masks stale data at the head
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
  assign dout = (level == '0) ? '0 : mem[rptr];
endmodule

// File: rtl/instr_encode.sv
// instr_encode: assembles MIPS-32 fields into R/I/J words, buffers them and tags each with a word address (optional INSTR_ENCODE_CHECK_EN adds shift-field sanity flags)
module instr_encode
  import instr_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 26,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_W-1:0]      opcode,
  input  logic [REG_W-1:0]         rs,
  input  logic [REG_W-1:0]         rt,
  input  logic [REG_W-1:0]         rd,
  input  logic [SHAMT_W-1:0]       shamt,
  input  logic [FUNCT_W-1:0]       funct,
  input  logic [IMM_W-1:0]         imm,
  input  logic [JADDR_W-1:0]       addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   level
`ifdef INSTR_ENCODE_CHECK_EN
  ,
  output logic                     err,
  output logic [7:0]               err_count
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef INSTR_ENCODE_CHECK_EN
  localparam int WIDTH = 33;
`else
  localparam int WIDTH = 32;
`endif
  fmt_t             fmt;
  logic [31:0]      word;
  logic             push, pop;
  logic [WIDTH-1:0] din, dout;
  // word layout follows the format implied by the opcode; unused fields drop out
  always_comb begin
    fmt  = fmt_of(opcode);
    word = (fmt == FMT_R) ? {opcode, rs, rt, rd, shamt, funct} :
           (fmt == FMT_J) ? {opcode, addr} : {opcode, rs, rt, imm};
  end
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign instr     = dout[31:0];
`ifdef INSTR_ENCODE_CHECK_EN
  logic flag;
  assign flag = (fmt == FMT_R) && (shamt != '0) && !(funct inside {FUNCT_SLL, FUNCT_SRL, FUNCT_SRA});
  assign din  = {flag, word};
  assign err  = out_valid && dout[32];
  // count flagged pushes, holding at the top of the range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= '0;
    else if (push && flag && err_count != 8'hFF) err_count <= err_count + 1'b1;
  end
`else
  assign din = word;
`endif
  // word address of the head advances once per accepted word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_addr <= BASE_ADDR;
    else if (pop) out_addr <= out_addr + 1'b1;
  end
  instr_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(din), .dout(dout), .level(level)
  );
endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: randomized and directed checks of instr_encode against a queue-based reference model
module tb_instr_encode;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [5:0]  opcode = 0, funct = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0, shamt = 0;
  logic [15:0] imm = 0;
  logic [25:0] addr = 0;
  logic [31:0] instr;
  logic [25:0] out_addr;
  logic [2:0]  level;
`ifdef INSTR_ENCODE_CHECK_EN
  logic        err;
  logic [7:0]  err_count;
`endif
  int vectors = 0, miscompares = 0;
  logic [31:0] mq[$];
  bit          fq[$];
  int          ea = 0, ecnt = 0;

  instr_encode #(.DEPTH(DEPTH), .ADDR_W(26), .BASE_ADDR(26'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .addr(addr), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_addr(out_addr), .level(level)
`ifdef INSTR_ENCODE_CHECK_EN
    , .err(err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_enc();
    longint w;
    w = longint'(opcode) * 64'd67108864;
    if (opcode == 0)
      w += longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(shamt) * 64 + longint'(funct);
    else if (opcode == 2 || opcode == 3)
      w += longint'(addr);
    else
      w += longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    return w[31:0];
  endfunction

  function automatic bit model_flag();
    return opcode == 0 && shamt != 0 && funct != 0 && funct != 2 && funct != 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("instr", 64'(instr), mq.size() != 0 ? 64'(mq[0]) : 64'd0);
    chk("out_addr", 64'(out_addr), 64'(ea % (1 << 26)));
`ifdef INSTR_ENCODE_CHECK_EN
    chk("err", 64'(err), 64'(mq.size() != 0 && fq[0]));
    chk("err_count", 64'(err_count), 64'(ecnt));
`endif
  endtask

  task automatic cyc();
    bit p, q;
    logic [31:0] w;
    bit f;
    p = in_valid && mq.size() != DEPTH;
    q = out_ready && mq.size() != 0;
    w = model_enc();
    f = model_flag();
    @(posedge clk);
    if (q) begin
      void'(mq.pop_front());
      void'(fq.pop_front());
      ea++;
    end
    if (p) begin
      mq.push_back(w);
      fq.push_back(f);
      if (f && ecnt < 255) ecnt++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_fields();
    opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom); addr = 26'($urandom);
  endtask

  task automatic do_reset();
    in_valid = 0;
    reset = 1;
    #1;
    mq.delete(); fq.delete(); ea = 0; ecnt = 0;
    @(negedge clk);
    reset = 0;
    check_all();
  endtask

  initial begin
    int guard;
    @(negedge clk);
    do_reset();
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // R-type directed word
    rand_fields();
    opcode = 0; rs = 0; rt = 1; rd = 2; shamt = 0; funct = 6'h20;
    in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("r_word", 64'(instr), 64'h00011020);
    chk("r_addr", 64'(out_addr), 64'd0);
    cyc();

    // J-type with random unused fields
    rand_fields();
    opcode = 3; addr = 26'h3;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("j_word", 64'(instr), 64'h0C000003);
    cyc();

    // I-type with random unused fields
    rand_fields();
    opcode = 8; rs = 1; rt = 2; imm = 16'hFFFF;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("i_word", 64'(instr), 64'h2022FFFF);
    cyc();

    // backpressure: fill to DEPTH, hold a fifth word, then drain in order
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      in_valid = 1;
      cyc();
    end
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_level", 64'(level), 64'd4);
    rand_fields();
    cyc();
    chk("bp_held_level", 64'(level), 64'd4);
    out_ready = 1;
    guard = 0;
    while (mq.size() == DEPTH && guard < 20) begin cyc(); guard++; end
    cyc();
    in_valid = 0;
    guard = 0;
    while (mq.size() != 0 && guard < 20) begin cyc(); guard++; end
    chk("bp_drain_bound", 64'(guard < 20), 64'd1);
    chk("bp_addr", 64'(out_addr), 64'd5);

    // steady state at level 2 with simultaneous push and pop
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin rand_fields(); in_valid = 1; cyc(); end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      cyc();
      chk("pp_level", 64'(level), 64'd2);
    end
    chk("pp_addr", 64'(out_addr), 64'd15);
    in_valid = 0;

    // asynchronous reset at level 3, between clock edges
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin rand_fields(); in_valid = 1; cyc(); end
    in_valid = 0;
    chk("ar_pre_level", 64'(level), 64'd3);
    #2 reset = 1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_level", 64'(level), 64'd0);
    chk("ar_out_addr", 64'(out_addr), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_instr", 64'(instr), 64'd0);
    mq.delete(); fq.delete(); ea = 0; ecnt = 0;
    @(negedge clk);
    reset = 0;
    rand_fields();
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("ar_first_addr", 64'(out_addr), 64'd0);
    out_ready = 1;
    cyc();

`ifdef INSTR_ENCODE_CHECK_EN
    do_reset();
    out_ready = 0;
    rand_fields();
    opcode = 0; funct = 6'h20; shamt = 3;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("ck_err", 64'(err), 64'd1);
    chk("ck_err_count", 64'(err_count), 64'd1);
    out_ready = 1;
    cyc();
    rand_fields();
    opcode = 0; funct = 6'h00; shamt = 3;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("ck_noerr", 64'(err), 64'd0);
    cyc();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      case ($urandom_range(3))
        0: opcode = 0;
        1: opcode = 2;
        2: opcode = 3;
        default: ;
      endcase
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
